// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives the PC onto the memory bus, waits on Mem_Ready,
// and queues fetched {word, address} pairs in a small FIFO that decode drains.
module fetch_unit #(
    parameter int DataWidth   = 16,
    parameter int AddrWidth   = 8,
    parameter int WordSize    = 1,
    parameter int ResetVector = 0,
    parameter int BufDepth    = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    output logic [AddrWidth-1:0] Mem_Addr,
    output logic                 Mem_Rd,
    input  logic                 Mem_Ready,
    input  logic [DataWidth-1:0] Mem_Data,
    output logic [DataWidth-1:0] Ir_Data,
    output logic [AddrWidth-1:0] Ir_PC,
    output logic                 Ir_Valid,
    input  logic                 Ir_Take,
    input  logic                 Redirect,
    input  logic [AddrWidth-1:0] Redirect_Addr,
    input  logic                 Halt,
    output logic                 Busy
);

    localparam int CntW = $clog2(BufDepth + 1);
    localparam int PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
    localparam logic [PtrW-1:0]      LastPtr = PtrW'(BufDepth - 1);
    localparam logic [CntW-1:0]      FullCnt = CntW'(BufDepth);
    localparam logic [AddrWidth-1:0] PcInc   = AddrWidth'(WordSize);
    localparam logic [AddrWidth-1:0] PcReset = AddrWidth'(ResetVector);

    typedef enum logic [1:0] {
        S_Reset,
        S_FetchPCtoMEM,
        S_FetchWait,
        S_Halted
    } state_t;

    state_t                state_reg;
    logic [AddrWidth-1:0]  pc_reg;
    logic                  mem_rd_reg;
    logic [CntW-1:0]       count_reg;
    logic [PtrW-1:0]       rd_ptr_reg;
    logic [PtrW-1:0]       wr_ptr_reg;
    logic [DataWidth-1:0]  data_mem [BufDepth];
    logic [AddrWidth-1:0]  pc_mem   [BufDepth];

    logic buf_valid;
    logic push;
    logic pop;
    logic slot_free;
    logic redirect_hit;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // Redirect wins over everything: it cancels both the pending push and any pop.
    assign redirect_hit = Redirect && (state_reg != S_Reset);
    assign buf_valid    = (count_reg != '0);
    assign pop          = Ir_Take && buf_valid && !redirect_hit;
    assign push         = (state_reg == S_FetchWait) && Mem_Ready && !redirect_hit;
    assign slot_free    = (count_reg != FullCnt) || pop;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg  <= S_Reset;
            pc_reg     <= PcReset;
            mem_rd_reg <= 1'b0;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
        end else if (redirect_hit) begin
            pc_reg     <= Redirect_Addr;
            mem_rd_reg <= 1'b0;
            count_reg  <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            state_reg  <= (state_reg == S_Halted) ? S_Halted : S_FetchPCtoMEM;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase

            case (state_reg)
                S_Reset: begin
                    state_reg <= S_FetchPCtoMEM;
                end
                S_FetchPCtoMEM: begin
                    if (Halt) begin
                        state_reg <= S_Halted;
                    end else if (slot_free) begin
                        state_reg  <= S_FetchWait;
                        mem_rd_reg <= 1'b1;
                    end
                end
                S_FetchWait: begin
                    // Halt is deliberately ignored here; the outstanding read always completes.
                    if (Mem_Ready) begin
                        pc_reg     <= pc_reg + PcInc;
                        mem_rd_reg <= 1'b0;
                        state_reg  <= S_FetchPCtoMEM;
                    end
                end
                S_Halted: begin
                    if (!Halt) begin
                        state_reg <= S_FetchPCtoMEM;
                    end
                end
                default: begin
                    state_reg <= S_Reset;
                end
            endcase
        end
    end

    // Payload storage needs no reset: the head is only exposed while the count is non-zero.
    always_ff @(posedge Clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= Mem_Data;
            pc_mem[wr_ptr_reg]   <= pc_reg;
        end
    end

    assign Mem_Addr = pc_reg;
    assign Mem_Rd   = mem_rd_reg;
    assign Ir_Valid = buf_valid;
    assign Ir_Data  = buf_valid ? data_mem[rd_ptr_reg] : '0;
    assign Ir_PC    = buf_valid ? pc_mem[rd_ptr_reg] : '0;
    assign Busy     = (state_reg == S_FetchPCtoMEM) || (state_reg == S_FetchWait);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-edge vector table for the main flow plus
// hand-written sequences for async reset and redirect while halted.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ready;
    logic [15:0] mem_data;
    logic        ir_take;
    logic        redirect;
    logic [7:0]  redirect_addr;
    logic        halt;

    logic [7:0]  mem_addr, ff_addr, w2_addr;
    logic        mem_rd, ff_rd, w2_rd;
    logic [15:0] ir_data, ff_data, w2_data;
    logic [7:0]  ir_pc, ff_pc, w2_pc;
    logic        ir_valid, ff_valid, w2_valid;
    logic        busy, ff_busy, w2_busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .Clk(clk), .Reset(rst_n), .Mem_Addr(mem_addr), .Mem_Rd(mem_rd),
        .Mem_Ready(mem_ready), .Mem_Data(mem_data), .Ir_Data(ir_data), .Ir_PC(ir_pc),
        .Ir_Valid(ir_valid), .Ir_Take(ir_take), .Redirect(redirect),
        .Redirect_Addr(redirect_addr), .Halt(halt), .Busy(busy)
    );

    fetch_unit #(.ResetVector(8'hFF), .WordSize(1)) dut_ff (
        .Clk(clk), .Reset(rst_n), .Mem_Addr(ff_addr), .Mem_Rd(ff_rd),
        .Mem_Ready(mem_ready), .Mem_Data(mem_data), .Ir_Data(ff_data), .Ir_PC(ff_pc),
        .Ir_Valid(ff_valid), .Ir_Take(ir_take), .Redirect(redirect),
        .Redirect_Addr(redirect_addr), .Halt(halt), .Busy(ff_busy)
    );

    fetch_unit #(.ResetVector(8'hFE), .WordSize(2)) dut_w2 (
        .Clk(clk), .Reset(rst_n), .Mem_Addr(w2_addr), .Mem_Rd(w2_rd),
        .Mem_Ready(mem_ready), .Mem_Data(mem_data), .Ir_Data(w2_data), .Ir_PC(w2_pc),
        .Ir_Valid(w2_valid), .Ir_Take(ir_take), .Redirect(redirect),
        .Redirect_Addr(redirect_addr), .Halt(halt), .Busy(w2_busy)
    );

    typedef struct {
        logic        ready;
        logic        take;
        logic        hlt;
        logic        redir;
        logic [7:0]  raddr;
        logic [15:0] data;
        logic [7:0]  e_addr;
        logic        e_rd;
        logic        e_valid;
        logic [15:0] e_data;
        logic [7:0]  e_pc;
        logic        e_busy;
    } vec_t;

    localparam int NumVec = 27;
    vec_t vecs [NumVec];

    function automatic vec_t mk(input logic ready, input logic take, input logic hlt,
                                input logic redir, input logic [7:0] raddr,
                                input logic [15:0] data, input logic [7:0] e_addr,
                                input logic e_rd, input logic e_valid,
                                input logic [15:0] e_data, input logic [7:0] e_pc,
                                input logic e_busy);
        vec_t v;
        v.ready = ready; v.take = take; v.hlt = hlt; v.redir = redir;
        v.raddr = raddr; v.data = data; v.e_addr = e_addr; v.e_rd = e_rd;
        v.e_valid = e_valid; v.e_data = e_data; v.e_pc = e_pc; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " addr"},  32'(mem_addr), 32'h00);
        chk({tag, " rd"},    32'(mem_rd),   32'h0);
        chk({tag, " valid"}, 32'(ir_valid), 32'h0);
        chk({tag, " data"},  32'(ir_data),  32'h0);
        chk({tag, " pc"},    32'(ir_pc),    32'h0);
        chk({tag, " busy"},  32'(busy),     32'h0);
    endtask

    initial begin
        // Each row is one clock edge; expectations are the outputs just after that edge.
        vecs[0]  = mk(1'b1,1'b1,1'b0,1'b0,8'h00,16'h0000, 8'h00,1'b0,1'b0,16'h0000,8'h00,1'b1);
        vecs[1]  = mk(1'b1,1'b1,1'b0,1'b0,8'h00,16'h0000, 8'h00,1'b1,1'b0,16'h0000,8'h00,1'b1);
        vecs[2]  = mk(1'b1,1'b1,1'b0,1'b0,8'h00,16'hA000, 8'h01,1'b0,1'b1,16'hA000,8'h00,1'b1);
        vecs[3]  = mk(1'b1,1'b1,1'b0,1'b0,8'h00,16'hA0FF, 8'h01,1'b1,1'b0,16'h0000,8'h00,1'b1);
        vecs[4]  = mk(1'b1,1'b1,1'b0,1'b0,8'h00,16'hA001, 8'h02,1'b0,1'b1,16'hA001,8'h01,1'b1);
        vecs[5]  = mk(1'b1,1'b1,1'b0,1'b0,8'h00,16'hA0FF, 8'h02,1'b1,1'b0,16'h0000,8'h00,1'b1);
        vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00,16'hB002, 8'h03,1'b0,1'b1,16'hB002,8'h02,1'b1);
        vecs[7]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00,16'h0000, 8'h03,1'b1,1'b1,16'hB002,8'h02,1'b1);
        vecs[8]  = mk(1'b1,1'b0,1'b0,1'b0,8'h00,16'hB003, 8'h04,1'b0,1'b1,16'hB002,8'h02,1'b1);
        vecs[9]  = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000, 8'h04,1'b0,1'b1,16'hB002,8'h02,1'b1);
        vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000, 8'h04,1'b0,1'b1,16'hB002,8'h02,1'b1);
        vecs[11] = mk(1'b0,1'b1,1'b0,1'b0,8'h00,16'h0000, 8'h04,1'b1,1'b1,16'hB003,8'h03,1'b1);
        vecs[12] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h1111, 8'h04,1'b1,1'b1,16'hB003,8'h03,1'b1);
        vecs[13] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h2222, 8'h04,1'b1,1'b1,16'hB003,8'h03,1'b1);
        vecs[14] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h3333, 8'h04,1'b1,1'b1,16'hB003,8'h03,1'b1);
        vecs[15] = mk(1'b1,1'b0,1'b0,1'b0,8'h00,16'hBEEF, 8'h05,1'b0,1'b1,16'hB003,8'h03,1'b1);
        vecs[16] = mk(1'b0,1'b1,1'b0,1'b0,8'h00,16'h0000, 8'h05,1'b1,1'b1,16'hBEEF,8'h04,1'b1);
        vecs[17] = mk(1'b1,1'b1,1'b0,1'b1,8'h40,16'hC005, 8'h40,1'b0,1'b0,16'h0000,8'h00,1'b1);
        vecs[18] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000, 8'h40,1'b1,1'b0,16'h0000,8'h00,1'b1);
        vecs[19] = mk(1'b1,1'b0,1'b0,1'b0,8'h00,16'hD040, 8'h41,1'b0,1'b1,16'hD040,8'h40,1'b1);
        vecs[20] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000, 8'h41,1'b1,1'b1,16'hD040,8'h40,1'b1);
        vecs[21] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,16'h0000, 8'h41,1'b1,1'b1,16'hD040,8'h40,1'b1);
        vecs[22] = mk(1'b1,1'b0,1'b1,1'b0,8'h00,16'hD041, 8'h42,1'b0,1'b1,16'hD040,8'h40,1'b1);
        vecs[23] = mk(1'b0,1'b0,1'b1,1'b0,8'h00,16'h0000, 8'h42,1'b0,1'b1,16'hD040,8'h40,1'b0);
        vecs[24] = mk(1'b0,1'b1,1'b1,1'b0,8'h00,16'h0000, 8'h42,1'b0,1'b1,16'hD041,8'h41,1'b0);
        vecs[25] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000, 8'h42,1'b0,1'b1,16'hD041,8'h41,1'b1);
        vecs[26] = mk(1'b0,1'b0,1'b0,1'b0,8'h00,16'h0000, 8'h42,1'b1,1'b1,16'hD041,8'h41,1'b1);

        rst_n = 1'b0; mem_ready = 1'b0; mem_data = 16'h0; ir_take = 1'b0;
        redirect = 1'b0; redirect_addr = 8'h00; halt = 1'b0;

        #12;
        chk_reset_outputs("reset");
        chk("reset ff_addr", 32'(ff_addr), 32'hFF);
        chk("reset w2_addr", 32'(w2_addr), 32'hFE);
        $display("txn reset: addr=%0h rd=%0b valid=%0b busy=%0b", mem_addr, mem_rd, ir_valid, busy);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NumVec; i++) begin
            mem_ready     = vecs[i].ready;
            ir_take       = vecs[i].take;
            halt          = vecs[i].hlt;
            redirect      = vecs[i].redir;
            redirect_addr = vecs[i].raddr;
            mem_data      = vecs[i].data;
            step();
            chk($sformatf("vec%0d addr", i),  32'(mem_addr), 32'(vecs[i].e_addr));
            chk($sformatf("vec%0d rd", i),    32'(mem_rd),   32'(vecs[i].e_rd));
            chk($sformatf("vec%0d valid", i), 32'(ir_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d busy", i),  32'(busy),     32'(vecs[i].e_busy));
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d ir_data", i), 32'(ir_data), 32'(vecs[i].e_data));
                chk($sformatf("vec%0d ir_pc", i),   32'(ir_pc),   32'(vecs[i].e_pc));
            end
            // Address wrap on the two alternative configurations after the first fetch.
            if (i == 1) begin
                chk("wrap ff first addr", 32'(ff_addr), 32'hFF);
                chk("wrap w2 first addr", 32'(w2_addr), 32'hFE);
            end
            if (i == 2) begin
                chk("wrap ff second addr", 32'(ff_addr), 32'h00);
                chk("wrap w2 second addr", 32'(w2_addr), 32'h00);
                chk("wrap ff ir_pc", 32'(ff_pc), 32'hFF);
            end
            $display("txn vec %0d: addr=%0h rd=%0b valid=%0b data=%0h pc=%0h busy=%0b",
                     i, mem_addr, mem_rd, ir_valid, ir_data, ir_pc, busy);
        end

        // Async reset in the middle of a wait, with the response arriving meanwhile.
        #2;
        mem_ready = 1'b1;
        mem_data  = 16'h5A5A;
        rst_n     = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        $display("txn async reset: addr=%0h rd=%0b valid=%0b busy=%0b", mem_addr, mem_rd, ir_valid, busy);
        step();
        chk_reset_outputs("held reset");
        $display("txn held reset: addr=%0h valid=%0b", mem_addr, ir_valid);

        // Redirect while halted: PC reloads but the unit stays halted.
        mem_ready = 1'b0;
        halt      = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("halted busy", 32'(busy), 32'h0);
        chk("halted rd",   32'(mem_rd), 32'h0);
        redirect      = 1'b1;
        redirect_addr = 8'h80;
        step();
        redirect = 1'b0;
        chk("halt redir addr", 32'(mem_addr), 32'h80);
        chk("halt redir busy", 32'(busy), 32'h0);
        chk("halt redir valid", 32'(ir_valid), 32'h0);
        $display("txn halted redirect: addr=%0h busy=%0b", mem_addr, busy);
        halt = 1'b0;
        step();
        chk("resume busy", 32'(busy), 32'h1);
        chk("resume rd",   32'(mem_rd), 32'h0);
        step();
        chk("resume fetch rd",   32'(mem_rd), 32'h1);
        chk("resume fetch addr", 32'(mem_addr), 32'h80);
        $display("txn resume: addr=%0h rd=%0b busy=%0b", mem_addr, mem_rd, busy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
